// File: rtl/color_fade_pwm.sv
// -----------------------------------------------------------------------------
// color_fade_pwm
//
// Tri-colour LED driver with linear colour fading. A 2-bit colour code from
// the colour PIO selects a palette entry. Each channel's level then ramps one
// step at a time toward that entry. Each channel drives its LED pin with PWM.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   color_in  in   colour code: 0=off, 1=red, 2=green, 3=blue
//   enable    in   0 forces the LED pins low; levels and fading keep running
//   led_r/g/b out  registered PWM outputs
//   busy      out  high while any channel level differs from its target
//   level_r/g/b out current channel levels (PWM_BITS wide)
//
// Build option:
//   COLOR_FADE_GAMMA_EN  when defined, each duty is (level*level) >> PWM_BITS.
//                        Full-scale level LMAX still maps to LMAX. Levels, busy
//                        and fade timing do not change.
//
// FSM states:
//   IDLE   | all levels equal the palette target, busy = 0
//   FADING | at least one level is still stepping toward its target, busy = 1
// -----------------------------------------------------------------------------
module color_fade_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 16,
    parameter int FADE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          color_in,
    input  logic                enable,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                busy,
    output logic [PWM_BITS-1:0] level_r,
    output logic [PWM_BITS-1:0] level_g,
    output logic [PWM_BITS-1:0] level_b
);

    localparam int PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] LMAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = LMAX - ONE;
    localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_TICKS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          target_code;
    logic [PSC_W-1:0]    psc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FADE_W-1:0]   fade_cnt;
    logic                tick;
    logic                period_end;
    logic                step;
    logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
    logic [PWM_BITS-1:0] nxt_r, nxt_g, nxt_b;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;

    function automatic logic [PWM_BITS-1:0] step_toward(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + ONE;
        end else if (cur > tgt) begin
            return cur - ONE;
        end
        return cur;
    endfunction

`ifdef COLOR_FADE_GAMMA_EN
    // Square law on the level. Full-scale stays constant high, because the
    // truncated square of LMAX would leave a low slot in every period.
    function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        if (lvl == LMAX) begin
            return LMAX;
        end
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`else
    function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
        return lvl;
    endfunction
`endif

    assign tick       = (psc == PSC_LAST);
    assign period_end = tick && (pwm_cnt == PWM_LAST);
    assign step       = period_end && (fade_cnt == FADE_LAST);

    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        case (target_code)
            2'd1:    tgt_r = LMAX;
            2'd2:    tgt_g = LMAX;
            2'd3:    tgt_b = LMAX;
            default: ;
        endcase
    end

    // The step uses the target_code value registered before this edge. A new
    // colour that arrives in the same cycle takes effect from the next step.
    always_comb begin
        nxt_r = level_r;
        nxt_g = level_g;
        nxt_b = level_b;
        if (step) begin
            nxt_r = step_toward(level_r, tgt_r);
            nxt_g = step_toward(level_g, tgt_g);
            nxt_b = step_toward(level_b, tgt_b);
        end
    end

    always_comb begin
        duty_r = duty_of(level_r);
        duty_g = duty_of(level_g);
        duty_b = duty_of(level_b);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ({level_r, level_g, level_b} != {tgt_r, tgt_g, tgt_b}) begin
                    state_nxt = FADING;
                end
            end
            FADING: begin
                // Also handles a retarget back to the current levels: nxt
                // then equals the target with no step taken.
                if ({nxt_r, nxt_g, nxt_b} == {tgt_r, tgt_g, tgt_b}) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == FADING);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            target_code <= 2'd0;
            psc         <= '0;
            pwm_cnt     <= '0;
            fade_cnt    <= '0;
            level_r     <= '0;
            level_g     <= '0;
            level_b     <= '0;
            led_r       <= 1'b0;
            led_g       <= 1'b0;
            led_b       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (color_in != target_code) begin
                target_code <= color_in;
            end

            if (tick) begin
                psc <= '0;
            end else begin
                psc <= psc + PSC_W'(1);
            end

            if (tick) begin
                if (pwm_cnt == PWM_LAST) begin
                    pwm_cnt <= '0;
                end else begin
                    pwm_cnt <= pwm_cnt + ONE;
                end
            end

            if (period_end) begin
                if (fade_cnt == FADE_LAST) begin
                    fade_cnt <= '0;
                end else begin
                    fade_cnt <= fade_cnt + FADE_W'(1);
                end
            end

            level_r <= nxt_r;
            level_g <= nxt_g;
            level_b <= nxt_b;

            // The PWM period is LMAX ticks (count 0..LMAX-1), so duty LMAX
            // is constant high and duty 0 is constant low.
            led_r <= enable && (pwm_cnt < duty_r);
            led_g <= enable && (pwm_cnt < duty_g);
            led_b <= enable && (pwm_cnt < duty_b);
        end
    end

endmodule
